// File: rtl/matriz_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : matriz_pkg
//  Brief    : Shared constants, status-word layout and input sanitiser for the
//             7x5 LED matrix scan controller.
//  Revision : 1.0  initial release
// ============================================================================
package matriz_pkg;

   localparam int         N_ROWS  = 7;
   localparam logic [2:0] ROW_OFF = 3'd7;

   // Bit positions inside the latched status word
   localparam int ST_CRIT  = 0;
   localparam int ST_BAIXO = 1;
   localparam int ST_MEDIO = 2;
   localparam int ST_ALTO  = 3;
   localparam int ST_ASP   = 4;
   localparam int ST_GOT   = 5;
   localparam int ST_W     = 6;

   typedef logic [ST_W-1:0] status_t;

   // One level bit at most (most severe wins); sprinkler beats drip.
   function automatic status_t sanitise(
      input logic crit,
      input logic baixo,
      input logic medio,
      input logic alto,
      input logic asp,
      input logic got
   );
      status_t s;
      s = '0;
      if (crit)       s[ST_CRIT]  = 1'b1;
      else if (baixo) s[ST_BAIXO] = 1'b1;
      else if (medio) s[ST_MEDIO] = 1'b1;
      else if (alto)  s[ST_ALTO]  = 1'b1;
      if (asp)        s[ST_ASP]   = 1'b1;
      else if (got)   s[ST_GOT]   = 1'b1;
      return s;
   endfunction

endpackage
`default_nettype wire

// File: rtl/mod_counter.sv
`default_nettype none
// ============================================================================
//  Module   : mod_counter
//  Brief    : Enabled modulo-MOD counter. wrap is high in the enabled cycle
//             whose edge returns the count to zero.
//  Revision : 1.0  initial release
// ============================================================================
module mod_counter #(
   parameter int MOD = 2,
   parameter int W   = (MOD > 1) ? $clog2(MOD) : 1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         en,
   output logic [W-1:0] count,
   output logic         wrap
);

   logic [W-1:0] count_q;
   logic [W-1:0] count_d;

   assign count = count_q;
   assign wrap  = en && (count_q == W'(MOD - 1));

   // Next count: hold, step, or fold back to zero at the terminal value
   always_comb begin
      count_d = count_q;
      if (wrap)    count_d = '0;
      else if (en) count_d = count_q + 1'b1;
   end

   // Count register
   always_ff @(posedge clk) begin
      if (rst) count_q <= '0;
      else     count_q <= count_d;
   end

endmodule
`default_nettype wire

// File: rtl/matriz_scan_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : matriz_scan_ctrl
//  Brief    : Row-scan and image-alternation timing for the 7x5 LED matrix.
//             Latches sanitised irrigation status once per frame.
//  Config   : GHOST_BLANK_EN - blank all rows for the first BLANK_CYCLES
//             cycles of every row slot (anti-ghosting).
//  Revision : 1.0  initial release
// ============================================================================
module matriz_scan_ctrl
   import matriz_pkg::*;
#(
   parameter int ROW_DIV      = 1000,
   parameter int ALT_FRAMES   = 50,
   parameter int BLANK_CYCLES = 50
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       Critico,
   input  logic       Baixo,
   input  logic       Medio,
   input  logic       Alto,
   input  logic       Aspersao,
   input  logic       Gotejamento,
   output logic [2:0] Clock_Linhas,
   output logic       img_sel,
   output logic [5:0] stat_q,
   output logic       frame_start
);

   localparam int DIV_W = (ROW_DIV > 1) ? $clog2(ROW_DIV) : 1;
   localparam int FRM_W = (ALT_FRAMES > 1) ? $clog2(ALT_FRAMES) : 1;

   logic [DIV_W-1:0] div_cnt;
   logic             row_tick;
   logic [2:0]       row_cnt;
   logic             frame_tick;
   logic [FRM_W-1:0] frame_cnt;
   logic             alt_wrap;

   mod_counter #(.MOD(ROW_DIV)) u_div (
      .clk   (clock),
      .rst   (reset),
      .en    (1'b1),
      .count (div_cnt),
      .wrap  (row_tick)
   );

   mod_counter #(.MOD(N_ROWS)) u_row (
      .clk   (clock),
      .rst   (reset),
      .en    (row_tick),
      .count (row_cnt),
      .wrap  (frame_tick)
   );

   mod_counter #(.MOD(ALT_FRAMES)) u_frame (
      .clk   (clock),
      .rst   (reset),
      .en    (frame_tick),
      .count (frame_cnt),
      .wrap  (alt_wrap)
   );

   status_t status_q, status_d;
   logic    phase_q, phase_d;
   logic    img_sel_q, img_sel_d;
   logic    frame_start_q, frame_start_d;

   // Frame-boundary updates; img_sel is built from next-state values so it
   // changes on the same edge as the status/phase it depends on.
   always_comb begin
      status_d      = status_q;
      phase_d       = phase_q;
      frame_start_d = frame_tick;
      if (frame_tick) begin
         status_d = sanitise(Critico, Baixo, Medio, Alto, Aspersao, Gotejamento);
      end
      if (alt_wrap) begin
         phase_d = ~phase_q;
      end
      img_sel_d = phase_d & ~status_d[ST_CRIT];
   end

   // Output and status registers
   always_ff @(posedge clock) begin
      if (reset) begin
         status_q      <= '0;
         phase_q       <= 1'b0;
         img_sel_q     <= 1'b0;
         frame_start_q <= 1'b0;
      end else begin
         status_q      <= status_d;
         phase_q       <= phase_d;
         img_sel_q     <= img_sel_d;
         frame_start_q <= frame_start_d;
      end
   end

   assign stat_q      = status_q;
   assign img_sel     = img_sel_q;
   assign frame_start = frame_start_q;

   // Counts whose value is not consumed; only their wrap pulses matter here
   logic unused_cnt;

`ifdef GHOST_BLANK_EN
   logic blank_q, blank_d;
   int   div_next;

   // Blank flag tracks the divider value the next edge will produce
   always_comb begin
      div_next = row_tick ? 0 : int'(div_cnt) + 1;
      blank_d  = (div_next < BLANK_CYCLES);
   end

   // Blank flag register; rows are off out of reset
   always_ff @(posedge clock) begin
      if (reset) blank_q <= 1'b1;
      else       blank_q <= blank_d;
   end

   assign Clock_Linhas = blank_q ? ROW_OFF : row_cnt;
   assign unused_cnt   = ^frame_cnt;
`else
   assign Clock_Linhas = row_cnt;
   assign unused_cnt   = ^{frame_cnt, div_cnt};
`endif

endmodule
`default_nettype wire

// File: tb/tb_matriz_scan_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_matriz_scan_ctrl
//  Brief    : Self-checking bench for matriz_scan_ctrl against a time-index
//             reference model (ROW_DIV=4, ALT_FRAMES=2, BLANK_CYCLES=1).
//  Config   : GHOST_BLANK_EN - also checks the blanking pattern.
//  Revision : 1.0  initial release
// ============================================================================
module tb_matriz_scan_ctrl;

   localparam int RD    = 4;
   localparam int ALT   = 2;
   localparam int BLK   = 1;
   localparam int NR    = 7;
   localparam int FRAME = RD * NR;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       crit = 1'b0, baixo = 1'b0, medio = 1'b0, alto = 1'b0, asp = 1'b0, got = 1'b0;
   logic [2:0] lin;
   logic       img;
   logic [5:0] stat;
   logic       fs;

   int errors = 0;
   int checks = 0;

   // Reference model state: cycles since reset and the status latched at the
   // most recent frame boundary.
   int         t = 0;
   logic [5:0] m_stat = '0;

   always #5 clk = ~clk;

   matriz_scan_ctrl #(
      .ROW_DIV      (RD),
      .ALT_FRAMES   (ALT),
      .BLANK_CYCLES (BLK)
   ) dut (
      .clock        (clk),
      .reset        (rst),
      .Critico      (crit),
      .Baixo        (baixo),
      .Medio        (medio),
      .Alto         (alto),
      .Aspersao     (asp),
      .Gotejamento  (got),
      .Clock_Linhas (lin),
      .img_sel      (img),
      .stat_q       (stat),
      .frame_start  (fs)
   );

   function automatic logic [5:0] ref_status(input logic c, b, m, a, s, g);
      logic [5:0] r;
      int         lvl;
      r   = '0;
      lvl = c ? 0 : b ? 1 : m ? 2 : a ? 3 : -1;
      if (lvl >= 0) r[lvl] = 1'b1;
      if (s)        r[4] = 1'b1;
      else if (g)   r[5] = 1'b1;
      return r;
   endfunction

   always @(posedge clk) begin
      if (rst) begin
         t      <= 0;
         m_stat <= '0;
      end else begin
         t <= t + 1;
         if ((t + 1) % FRAME == 0) m_stat <= ref_status(crit, baixo, medio, alto, asp, got);
      end
   end

   function automatic logic [2:0] exp_lin();
      int row;
      row = (t / RD) % NR;
`ifdef GHOST_BLANK_EN
      if ((t % RD) < BLK) return 3'd7;
`endif
      return 3'(row);
   endfunction

   function automatic logic exp_fs();
      return (t > 0) && (t % FRAME == 0);
   endfunction

   function automatic logic exp_img();
      return (((t / FRAME) / ALT) % 2 == 1) && !m_stat[0];
   endfunction

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_reset();
      @(negedge clk);
      rst = 1'b1;
      {crit, baixo, medio, alto, asp, got} = 6'b111111;
      repeat (2) @(negedge clk);
`ifdef GHOST_BLANK_EN
      checks++; if (lin !== 3'd7) begin errors++; $display("FAIL reset_lin got %0d want 7", lin); end
`else
      checks++; if (lin !== 3'd0) begin errors++; $display("FAIL reset_lin got %0d want 0", lin); end
`endif
      checks++; if (img !== 1'b0) begin errors++; $display("FAIL reset_img got %b want 0", img); end
      checks++; if (stat !== 6'd0) begin errors++; $display("FAIL reset_stat got %b want 000000", stat); end
      checks++; if (fs !== 1'b0) begin errors++; $display("FAIL reset_fs got %b want 0", fs); end
      {crit, baixo, medio, alto, asp, got} = 6'b000000;
      rst = 1'b0;
   endtask

   task automatic test_scan();
      int seen7;
      seen7 = 0;
      do_reset();
      for (int i = 0; i < 60; i++) begin
         checks++;
         if (lin !== exp_lin()) begin
            errors++; $display("FAIL scan_lin t=%0d got %0d want %0d", t, lin, exp_lin());
         end
         if (lin === 3'd7) seen7++;
         @(negedge clk);
      end
`ifndef GHOST_BLANK_EN
      checks++; if (seen7 != 0) begin errors++; $display("FAIL scan_no_off got %0d cycles of 7 want 0", seen7); end
`endif
   endtask

   task automatic test_frame();
      int pulses, toggles;
      logic prev_img;
      pulses = 0; toggles = 0;
      do_reset();
      prev_img = img;
      for (int i = 0; i < 120; i++) begin
         checks++;
         if (fs !== exp_fs()) begin errors++; $display("FAIL frame_fs t=%0d got %b want %b", t, fs, exp_fs()); end
         checks++;
         if (img !== exp_img()) begin errors++; $display("FAIL frame_img t=%0d got %b want %b", t, img, exp_img()); end
         if (fs === 1'b1) pulses++;
         if (img !== prev_img) toggles++;
         prev_img = img;
         @(negedge clk);
      end
      checks++; if (pulses != 4) begin errors++; $display("FAIL frame_pulses got %0d want 4", pulses); end
      checks++; if (toggles != 2) begin errors++; $display("FAIL img_toggles got %0d want 2", toggles); end
   endtask

   task automatic test_latch();
      int guard;
      do_reset();
      guard = 0;
      while (t != FRAME + 3 * RD && guard < 200) begin @(negedge clk); guard++; end
      checks++; if (guard >= 200) begin errors++; $display("FAIL latch_wait timeout t=%0d want %0d", t, FRAME + 3 * RD); end
      baixo = 1'b1;
      while (t < 2 * FRAME + 2 && guard < 400) begin
         checks++;
         if (stat !== m_stat) begin errors++; $display("FAIL latch_stat t=%0d got %b want %b", t, stat, m_stat); end
         if (t == 2 * FRAME - 1) begin
            checks++; if (stat !== 6'b000000) begin errors++; $display("FAIL latch_hold got %b want 000000", stat); end
         end
         if (t == 2 * FRAME) begin
            checks++; if (stat !== 6'b000010) begin errors++; $display("FAIL latch_load got %b want 000010", stat); end
         end
         @(negedge clk); guard++;
      end
      baixo = 1'b0;
   endtask

   task automatic test_priority();
      do_reset();
      {crit, baixo, medio, alto, asp, got} = 6'b110011;
      for (int i = 0; i < 120; i++) begin
         if (t >= FRAME) begin
            checks++;
            if (stat !== 6'b010001) begin errors++; $display("FAIL prio_stat t=%0d got %b want 010001", t, stat); end
         end
         checks++;
         if (img !== 1'b0) begin errors++; $display("FAIL prio_img t=%0d got %b want 0", t, img); end
         @(negedge clk);
      end
      {crit, baixo, medio, alto, asp, got} = 6'b000000;
   endtask

   task automatic test_reset_mid();
      int guard;
      do_reset();
      asp = 1'b1;
      guard = 0;
      while (t != 2 * FRAME + 4 * RD + 2 && guard < 200) begin @(negedge clk); guard++; end
      checks++; if (guard >= 200) begin errors++; $display("FAIL mid_wait timeout t=%0d", t); end
      checks++; if (lin !== 3'd4) begin errors++; $display("FAIL mid_pre_lin got %0d want 4", lin); end
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      checks++; if (stat !== 6'd0) begin errors++; $display("FAIL mid_stat got %b want 000000", stat); end
      checks++; if (fs !== 1'b0) begin errors++; $display("FAIL mid_fs got %b want 0", fs); end
      checks++; if (img !== 1'b0) begin errors++; $display("FAIL mid_img got %b want 0", img); end
      for (int i = 0; i < 40; i++) begin
         checks++;
         if (lin !== exp_lin()) begin errors++; $display("FAIL mid_lin t=%0d got %0d want %0d", t, lin, exp_lin()); end
         @(negedge clk);
      end
      asp = 1'b0;
   endtask

   task automatic test_random();
      do_reset();
      for (int i = 0; i < 1500; i++) begin
         checks++;
         if (lin !== exp_lin()) begin errors++; $display("FAIL rand_lin t=%0d got %0d want %0d", t, lin, exp_lin()); end
         checks++;
         if (fs !== exp_fs()) begin errors++; $display("FAIL rand_fs t=%0d got %b want %b", t, fs, exp_fs()); end
         checks++;
         if (stat !== m_stat) begin errors++; $display("FAIL rand_stat t=%0d got %b want %b", t, stat, m_stat); end
         checks++;
         if (img !== exp_img()) begin errors++; $display("FAIL rand_img t=%0d got %b want %b", t, img, exp_img()); end
         crit  = ($urandom % 6 == 0);
         baixo = ($urandom % 3 == 0);
         medio = ($urandom % 3 == 0);
         alto  = ($urandom % 2 == 0);
         asp   = ($urandom % 2 == 0);
         got   = ($urandom % 2 == 0);
         rst   = ($urandom % 300 == 0);
         @(negedge clk);
      end
      rst = 1'b0;
      {crit, baixo, medio, alto, asp, got} = 6'b000000;
   endtask

`ifdef GHOST_BLANK_EN
   task automatic test_ghost();
      do_reset();
      checks++; if (lin !== 3'd7) begin errors++; $display("FAIL ghost_reset got %0d want 7", lin); end
      for (int i = 0; i < 2 * FRAME; i++) begin
         checks++;
         if (((t % RD) == 0) ? (lin !== 3'd7) : (lin !== 3'((t / RD) % NR))) begin
            errors++; $display("FAIL ghost_lin t=%0d got %0d want %0d", t, lin, exp_lin());
         end
         @(negedge clk);
      end
   endtask
`endif

   initial begin
      test_reset();
      test_scan();
      test_frame();
      test_latch();
      test_priority();
      test_reset_mid();
`ifdef GHOST_BLANK_EN
      test_ghost();
`endif
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
